// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// State encoding and default byte-wait timeout.
package fetch_pkg;

  localparam int FETCH_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ_LO,
    REQ_HI,
    DONE,
    ERROR
  } fetch_state_t;

endpackage

// File: rtl/fetch_wait_timer.sv
// Per-byte wait counter for the fetch sequencer.
// Raises tc when TIMEOUT-1 cycles have been waited.
module fetch_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetches one 16-bit instruction as two byte reads,
// low byte first, with per-byte timeout and abort.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = FETCH_TIMEOUT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic Abort,
  input  logic Clear,
  input  logic MemAck,
  output logic MemReq,
  output logic IR_Write,
  output logic IR_LH,
  output logic PC_Inc,
  output logic Busy,
  output logic InstrValid,
  output logic Error
);

  fetch_state_t state, next;
  logic         tc;
  logic         req;
  logic         clr;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (Start) next = REQ_LO;
      end
      REQ_LO: begin
        if (Abort)       next = IDLE;
        else if (MemAck) next = REQ_HI;
        else if (tc)     next = ERROR;
      end
      REQ_HI: begin
        if (Abort)       next = IDLE;
        else if (MemAck) next = DONE;
        else if (tc)     next = ERROR;
      end
      DONE: begin
        if (Abort)      next = IDLE;
        else if (Start) next = REQ_LO;
        else            next = IDLE;
      end
      ERROR: begin
        if (Clear) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Counter is zero on every state change, so it starts fresh per byte.
  assign req = (state == REQ_LO) || (state == REQ_HI);
  assign clr = (next != state);

  fetch_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .Clock(Clock),
    .Reset(Reset),
    .clr  (clr),
    .inc  (req && !clr),
    .tc   (tc)
  );

  always_comb begin
    MemReq     = 1'b0;
    IR_Write   = 1'b0;
    IR_LH      = 1'b0;
    PC_Inc     = 1'b0;
    Busy       = 1'b0;
    InstrValid = 1'b0;
    Error      = 1'b0;
    unique case (state)
      REQ_LO: begin
        MemReq   = 1'b1;
        Busy     = 1'b1;
        IR_Write = MemAck && !Abort;
        PC_Inc   = MemAck && !Abort;
      end
      REQ_HI: begin
        MemReq   = 1'b1;
        Busy     = 1'b1;
        IR_LH    = 1'b1;
        IR_Write = MemAck && !Abort;
        PC_Inc   = MemAck && !Abort;
      end
      DONE: begin
        InstrValid = !Abort;
      end
      ERROR: begin
        Error = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer.
// A cycle model pushes expected outputs to a scoreboard.
module tb_fetch_sequencer;

  localparam int T = 4;

  localparam int M_IDLE = 0;
  localparam int M_LO   = 1;
  localparam int M_HI   = 2;
  localparam int M_DONE = 3;
  localparam int M_ERR  = 4;

  logic Clock, Reset;
  logic Start, Abort, Clear, MemAck;
  logic MemReq, IR_Write, IR_LH, PC_Inc;
  logic Busy, InstrValid, Error;
  logic [6:0] outs;

  int nchk  = 0;
  int nfail = 0;
  int m_st  = M_IDLE;
  int m_cnt = 0;
  logic [6:0] sb[$];

  fetch_sequencer #(
    .TIMEOUT(T)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Abort     (Abort),
    .Clear     (Clear),
    .MemAck    (MemAck),
    .MemReq    (MemReq),
    .IR_Write  (IR_Write),
    .IR_LH     (IR_LH),
    .PC_Inc    (PC_Inc),
    .Busy      (Busy),
    .InstrValid(InstrValid),
    .Error     (Error)
  );

  // bit order: MemReq IR_Write IR_LH PC_Inc Busy InstrValid Error
  assign outs = {MemReq, IR_Write, IR_LH, PC_Inc,
                 Busy, InstrValid, Error};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // v = {Start, Abort, Clear, MemAck}
  task automatic cyc(input logic [3:0] v);
    logic [6:0] e;
    int nx;
    {Start, Abort, Clear, MemAck} = v;
    e  = '0;
    nx = m_st;
    case (m_st)
      M_IDLE: if (v[3]) nx = M_LO;
      M_LO, M_HI: begin
        e[6] = 1'b1;
        e[2] = 1'b1;
        e[4] = (m_st == M_HI);
        if (v[2]) nx = M_IDLE;
        else if (v[0]) begin
          e[5] = 1'b1;
          e[3] = 1'b1;
          nx = (m_st == M_LO) ? M_HI : M_DONE;
        end
        else if (m_cnt == T - 1) nx = M_ERR;
        else m_cnt++;
      end
      M_DONE: begin
        e[1] = !v[2];
        nx = v[2] ? M_IDLE : (v[3] ? M_LO : M_IDLE);
      end
      M_ERR: begin
        e[0] = 1'b1;
        if (v[1]) nx = M_IDLE;
      end
      default: nx = M_IDLE;
    endcase
    if (nx != m_st) m_cnt = 0;
    m_st = nx;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    logic [3:0] stim[$];
    logic [6:0] exp, obs;
    Reset = 1'b0;
    {Start, Abort, Clear, MemAck} = 4'b1001;
    #2;
    nchk++;
    if (outs !== 7'b0) begin
      nfail++;
      $display("FAIL reset_async got %b exp %b", outs, 7'b0);
    end
    @(posedge Clock);
    #1;
    nchk++;
    if (outs !== 7'b0) begin
      nfail++;
      $display("FAIL reset_hold got %b exp %b", outs, 7'b0);
    end
    {Start, Abort, Clear, MemAck} = 4'b0000;
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    stim = '{4'b0001, 4'b0100, 4'b0010, 4'b0000};
    foreach (stim[i]) begin
      cyc(stim[i]);
      @(negedge Clock);
      obs = outs;
      exp = sb.pop_front();
      nchk++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL reset_idle[%0d] got %b exp %b", i, obs, exp);
      end
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_single_fetch();
    logic [3:0] stim[$];
    logic [6:0] exp, obs;
    int pcs = 0;
    int iv_at = -1;
    int lo_at = -1;
    int hi_at = -1;
    stim = '{4'b1000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    foreach (stim[i]) begin
      cyc(stim[i]);
      @(negedge Clock);
      obs = outs;
      exp = sb.pop_front();
      nchk++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL single[%0d] got %b exp %b", i, obs, exp);
      end
      if (PC_Inc) pcs++;
      if (InstrValid) iv_at = i;
      if (IR_Write && !IR_LH) lo_at = i;
      if (IR_Write && IR_LH) hi_at = i;
      @(posedge Clock);
      #1;
    end
    nchk++;
    if (pcs != 2 || iv_at != 3 || lo_at != 1 || hi_at != 2) begin
      nfail++;
      $display("FAIL single_timing got pc=%0d iv=%0d lo=%0d hi=%0d exp 2 3 1 2",
               pcs, iv_at, lo_at, hi_at);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] stim[$];
    logic [6:0] exp, obs;
    int ivs[$];
    int busy_gap = 0;
    stim.push_back(4'b1000);
    for (int f = 0; f < 3; f++) begin
      stim.push_back(4'b1000);
      stim.push_back(4'b1000);
      stim.push_back(4'b1001);
      stim.push_back(4'b1000);
      stim.push_back(4'b1000);
      stim.push_back(4'b1001);
      stim.push_back((f == 2) ? 4'b0000 : 4'b1000);
    end
    stim.push_back(4'b0000);
    foreach (stim[i]) begin
      cyc(stim[i]);
      @(negedge Clock);
      obs = outs;
      exp = sb.pop_front();
      nchk++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL b2b[%0d] got %b exp %b", i, obs, exp);
      end
      if (InstrValid) ivs.push_back(i);
      if ((i == 8 || i == 15) && !Busy) busy_gap++;
      @(posedge Clock);
      #1;
    end
    nchk++;
    if (ivs.size() != 3) begin
      nfail++;
      $display("FAIL b2b_count got %0d exp 3", ivs.size());
    end else begin
      if (ivs[0] != 7 || ivs[1] - ivs[0] != 7 ||
          ivs[2] - ivs[1] != 7 || busy_gap != 0) begin
        nfail++;
        $display("FAIL b2b_period got %0d %0d %0d gap=%0d exp 7 14 21 0",
                 ivs[0], ivs[1], ivs[2], busy_gap);
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] stim[$];
    logic [6:0] exp, obs;
    int err_at = -1;
    stim = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
             4'b1000, 4'b1000, 4'b0100, 4'b0001,
             4'b0010, 4'b0000};
    foreach (stim[i]) begin
      cyc(stim[i]);
      @(negedge Clock);
      obs = outs;
      exp = sb.pop_front();
      nchk++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL timeout[%0d] got %b exp %b", i, obs, exp);
      end
      if (Error && err_at < 0) err_at = i;
      @(posedge Clock);
      #1;
    end
    nchk++;
    if (err_at != 5 || Error !== 1'b0) begin
      nfail++;
      $display("FAIL timeout_entry got at=%0d err=%b exp 5 0",
               err_at, Error);
    end
  endtask

  task automatic test_ack_at_limit();
    logic [3:0] stim[$];
    logic [6:0] exp, obs;
    int hi_at = -1;
    int errs = 0;
    stim = '{4'b1000,
             4'b0000, 4'b0000, 4'b0000, 4'b0001,
             4'b0000, 4'b0000, 4'b0000, 4'b0001,
             4'b0000, 4'b0000};
    foreach (stim[i]) begin
      cyc(stim[i]);
      @(negedge Clock);
      obs = outs;
      exp = sb.pop_front();
      nchk++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL limit[%0d] got %b exp %b", i, obs, exp);
      end
      if (IR_Write && IR_LH) hi_at = i;
      if (Error) errs++;
      @(posedge Clock);
      #1;
    end
    nchk++;
    if (hi_at != 8 || errs != 0) begin
      nfail++;
      $display("FAIL limit_hi got at=%0d errs=%0d exp 8 0", hi_at, errs);
    end
  endtask

  task automatic test_abort();
    logic [3:0] stim[$];
    logic [6:0] exp, obs;
    int writes = 0;
    int ivs = 0;
    stim = '{4'b1000, 4'b0001, 4'b0101, 4'b0001,
             4'b1000, 4'b0100, 4'b0000,
             4'b1000, 4'b0001, 4'b0001, 4'b1100, 4'b0000};
    foreach (stim[i]) begin
      cyc(stim[i]);
      @(negedge Clock);
      obs = outs;
      exp = sb.pop_front();
      nchk++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL abort[%0d] got %b exp %b", i, obs, exp);
      end
      if (IR_Write) writes++;
      if (InstrValid) ivs++;
      @(posedge Clock);
      #1;
    end
    nchk++;
    if (writes != 3 || ivs != 0) begin
      nfail++;
      $display("FAIL abort_suppress got wr=%0d iv=%0d exp 3 0", writes, ivs);
    end
  endtask

  task automatic test_reset_midfetch();
    logic [3:0] stim[$];
    logic [6:0] exp, obs;
    int stray = 0;
    stim = '{4'b1000, 4'b0001, 4'b0001};
    foreach (stim[i]) begin
      cyc(stim[i]);
      @(negedge Clock);
      obs = outs;
      exp = sb.pop_front();
      nchk++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL midrst_pre[%0d] got %b exp %b", i, obs, exp);
      end
      if (i < 2) begin
        @(posedge Clock);
        #1;
      end
    end
    #2 Reset = 1'b0;
    #1;
    nchk++;
    if (outs !== 7'b0) begin
      nfail++;
      $display("FAIL midrst_async got %b exp %b", outs, 7'b0);
    end
    m_st = M_IDLE;
    m_cnt = 0;
    @(posedge Clock);
    #3 Reset = 1'b1;
    @(posedge Clock);
    #1;
    stim = '{4'b0001, 4'b0001, 4'b0000,
             4'b1000, 4'b0001, 4'b0001, 4'b0000};
    foreach (stim[i]) begin
      cyc(stim[i]);
      @(negedge Clock);
      obs = outs;
      exp = sb.pop_front();
      nchk++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL midrst_post[%0d] got %b exp %b", i, obs, exp);
      end
      if (i < 3 && (IR_Write || PC_Inc)) stray++;
      @(posedge Clock);
      #1;
    end
    nchk++;
    if (stray != 0) begin
      nfail++;
      $display("FAIL midrst_stray got %0d exp 0", stray);
    end
  endtask

  initial begin
    Reset  = 1'b0;
    Start  = 1'b0;
    Abort  = 1'b0;
    Clear  = 1'b0;
    MemAck = 1'b0;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_timeout();
    test_ack_at_limit();
    test_abort();
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
